detect_event_logger: RTL and testbench



---
 rtl/detect_event_logger.sv | 126 ++++++++++++
 tb/tb_detect_event_logger.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/detect_event_logger.sv
// Event logger for the sequence detector flags: saturating per-flag counters,
// a free-running timestamp, and a first-word-fall-through FIFO of tagged timestamps.
module detect_event_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       F0,
  input  logic                       F1,
  input  logic                       clr,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [TS_W+1:0]            rd_data,
  output logic [CNT_W-1:0]           cnt0,
  output logic [CNT_W-1:0]           cnt1,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = TS_W + 2;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];

  logic event_s, full_s, empty_s, pop_s, push_s;

  // Next-state logic: a pop in the same cycle frees the slot a full-FIFO write needs.
  always_comb begin
    event_s    = F0 | F1;
    full_s     = (level_q == LVL_W'(DEPTH));
    empty_s    = (level_q == {LVL_W{1'b0}});
    pop_s      = !empty_s && rd_ready;
    push_s     = event_s && (!full_s || pop_s);
    ts_d       = ts_q + TS_W'(1'b1);
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    level_d    = level_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;
    if (clr) begin
      ts_d       = {TS_W{1'b0}};
      cnt0_d     = {CNT_W{1'b0}};
      cnt1_d     = {CNT_W{1'b0}};
      level_d    = {LVL_W{1'b0}};
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      overflow_d = 1'b0;
    end else begin
      if (F0 && (cnt0_q != {CNT_W{1'b1}})) begin
        cnt0_d = cnt0_q + CNT_W'(1'b1);
      end else begin
        cnt0_d = cnt0_q;
      end
      if (F1 && (cnt1_q != {CNT_W{1'b1}})) begin
        cnt1_d = cnt1_q + CNT_W'(1'b1);
      end else begin
        cnt1_d = cnt1_q;
      end
      if (push_s) begin
        mem_d[wr_ptr_q] = {F1, F0, ts_q};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_W'(1'b1);
        2'b01:   level_d = level_q - LVL_W'(1'b1);
        default: level_d = level_q;
      endcase
      if (event_s && full_s && !pop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ts_q       <= {TS_W{1'b0}};
      cnt0_q     <= {CNT_W{1'b0}};
      cnt1_q     <= {CNT_W{1'b0}};
      level_q    <= {LVL_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {ENT_W{1'b0}};
      end
    end else begin
      ts_q       <= ts_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign rd_valid = (level_q != {LVL_W{1'b0}});
  assign rd_data  = mem_q[rd_ptr_q];
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_detect_event_logger.sv
// Scoreboard bench for detect_event_logger: stimulus queues expected entries,
// a negedge monitor checks every popped head against the queue.
module tb_detect_event_logger;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        F0 = 1'b0, F1 = 1'b0, clr = 1'b0, rd_ready = 1'b0;
  logic        rd_valid, overflow;
  logic [17:0] rd_data;
  logic [7:0]  cnt0, cnt1;
  logic [3:0]  level;

  int tests = 0;
  int fails = 0;
  logic [17:0] exp_q [$];

  detect_event_logger #(.TS_W(16), .DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .res(res), .F0(F0), .F1(F1), .clr(clr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .cnt0(cnt0), .cnt1(cnt1),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] ent(input logic [1:0] tag, input int ts);
    return {tag, 16'(ts)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic f0, input logic f1, input logic rdy, input logic c);
    F0 = f0; F1 = f1; rd_ready = rdy; clr = c;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake visible at negedge means the head pops on the next edge.
  always @(negedge clk) begin
    if (!res && rd_valid && rd_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got %0h expected no entry", rd_data);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          fails++;
          $display("FAIL pop_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  initial begin
    @(posedge clk); @(posedge clk); #1;
    res = 1'b0;
    check("rst_valid", rd_valid, 0);
    check("rst_level", level, 0);

    // Idle 10 edges: ts reaches 10
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_cnt0", cnt0, 0);
    check("idle_cnt1", cnt1, 0);
    check("idle_valid", rd_valid, 0);
    check("idle_ovf", overflow, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0); exp_q.push_back(ent(2'b01, 10));
    check("ev10_valid", rd_valid, 1);
    check("ev10_data", rd_data, ent(2'b01, 10));
    check("ev10_cnt0", cnt0, 1);
    check("ev10_level", level, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("hold_data", rd_data, ent(2'b01, 10));
    check("hold_valid", rd_valid, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("pop_valid", rd_valid, 0);
    check("pop_level", level, 0);

    // clr restarts ts; event at ts=5
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_cnt0", cnt0, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0); exp_q.push_back(ent(2'b01, 5));
    check("ev5_data", rd_data, ent(2'b01, 5));
    check("ev5_cnt0", cnt0, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0); exp_q.push_back(ent(2'b11, 20));
    check("both_level", level, 1);
    check("both_data", rd_data, ent(2'b11, 20));
    check("both_cnt0", cnt0, 2);
    check("both_cnt1", cnt1, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("both_pop_level", level, 0);

    // Fill past full: ts 30..37 stored, 38 and 39 dropped
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (i < 8) exp_q.push_back(ent(2'b10, 30 + i));
    end
    check("full_level", level, 8);
    check("full_ovf", overflow, 1);
    check("full_cnt1", cnt1, 11);
    check("full_head", rd_data, ent(2'b10, 30));

    // Full with simultaneous pop and write
    step(1'b1, 1'b0, 1'b1, 1'b0); exp_q.push_back(ent(2'b01, 40));
    check("fullrw_level", level, 8);
    check("fullrw_ovf", overflow, 1);
    check("fullrw_cnt0", cnt0, 3);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_level", level, 0);
    check("drain_ovf_sticky", overflow, 1);

    // Streaming at level 1 while saturating cnt0
    for (int i = 0; i < 252; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      exp_q.push_back(ent(2'b01, 49 + i));
    end
    check("sat_cnt0", cnt0, 255);
    check("stream_level", level, 1);
    check("stream_valid", rd_valid, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0); exp_q.push_back(ent(2'b01, 301));
    check("sat_hold_cnt0", cnt0, 255);

    // clr with a concurrent event is ignored
    step(1'b1, 1'b0, 1'b0, 1'b1);
    exp_q.delete();
    check("clr2_cnt0", cnt0, 0);
    check("clr2_cnt1", cnt1, 0);
    check("clr2_level", level, 0);
    check("clr2_ovf", overflow, 0);
    check("clr2_valid", rd_valid, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0); exp_q.push_back(ent(2'b10, 0));
    check("clr2_ev_data", rd_data, ent(2'b10, 0));
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Async reset between edges
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_res_cnt0", cnt0, 2);
    check("pre_res_level", level, 2);
    F0 = 1'b0;
    #2 res = 1'b1;
    #1;
    check("ares_cnt0", cnt0, 0);
    check("ares_level", level, 0);
    check("ares_valid", rd_valid, 0);
    res = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0); exp_q.push_back(ent(2'b01, 0));
    check("post_res_data", rd_data, ent(2'b01, 0));
    check("post_res_cnt0", cnt0, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("end_level", level, 0);
    check("end_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
